// File: rtl/cache_types_pkg.sv
// Shared cache types: word type, icache FSM states, frame record and a
// saturating counter helper.
package cache_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE,
    FETCH
  } icache_state_t;

  // Tag is kept as a full right-shifted address word so the frame layout
  // does not depend on the number of sets.
  typedef struct packed {
    logic  valid;
    word_t tag;
    word_t data;
  } icache_frame_t;

  function automatic word_t sat_inc(input word_t v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped frame storage: one synchronous write port, one combinational
// read port, asynchronous clear of every frame.
module icache_array
  import cache_types_pkg::*;
#(
  parameter int unsigned SETS = 16,
  parameter int unsigned IDXW = $clog2(SETS)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_we,
  input  logic [IDXW-1:0] i_widx,
  input  icache_frame_t   i_wframe,
  input  logic [IDXW-1:0] i_ridx,
  output icache_frame_t   o_rframe
);

  icache_frame_t r_frames [SETS];

  // Clear all frames on reset, otherwise write the addressed frame on a fill.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < SETS; i++) begin
        r_frames[i] <= '0;
      end
    end else if (i_we) begin
      r_frames[i_widx] <= i_wframe;
    end
  end

  assign o_rframe = r_frames[i_ridx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache. Zero-latency hits in
// IDLE; a miss latches the word address and stays in FETCH until memory
// returns the word, regardless of what the datapath does meanwhile.
module icache
  import cache_types_pkg::*;
#(
  parameter int unsigned SETS    = 16,
  parameter logic [31:0] PC_INIT = '0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned IDXW = $clog2(SETS);

  generate
    if (SETS < 4 || SETS > 64 || (SETS & (SETS - 1)) != 0 || PC_INIT[1:0] != 2'b00) begin : g_bad_param
      $error("icache: SETS must be a power of 2 in 4..64 and PC_INIT word aligned");
    end
  endgenerate

  icache_state_t r_state;
  word_t         r_miss_addr;
  word_t         r_hit_count;
  word_t         r_miss_count;

  logic [IDXW-1:0] w_idx;
  word_t           w_tag;
  word_t           w_word_addr;
  icache_frame_t   w_rframe;
  logic            w_hit;
  logic            w_fill;
  logic [IDXW-1:0] w_fill_idx;
  icache_frame_t   w_fill_frame;

  // Split the request address and form the fill record from the latched miss.
  always_comb begin
    w_idx        = imemaddr[IDXW+1:2];
    w_tag        = word_t'(imemaddr >> (IDXW + 2));
    w_word_addr  = imemaddr & 32'hFFFF_FFFC;
    w_hit        = (r_state == IDLE) && imemREN && w_rframe.valid && (w_rframe.tag == w_tag);
    w_fill       = (r_state == FETCH) && !iwait;
    w_fill_idx   = r_miss_addr[IDXW+1:2];
    w_fill_frame = '{valid: 1'b1, tag: word_t'(r_miss_addr >> (IDXW + 2)), data: iload};
  end

  icache_array #(
    .SETS(SETS),
    .IDXW(IDXW)
  ) u_array (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_we    (w_fill),
    .i_widx  (w_fill_idx),
    .i_wframe(w_fill_frame),
    .i_ridx  (w_idx),
    .o_rframe(w_rframe)
  );

  // Miss FSM with saturating hit/miss counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_miss_addr  <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_hit_count <= sat_inc(r_hit_count);
          end else if (imemREN) begin
            r_miss_addr  <= w_word_addr;
            r_miss_count <= sat_inc(r_miss_count);
            r_state      <= FETCH;
          end
        end
        FETCH: begin
          if (!iwait) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ihit       = w_hit;
  assign imemload   = w_hit ? w_rframe.data : '0;
  assign iREN       = (r_state == FETCH);
  assign iaddr      = (r_state == FETCH) ? r_miss_addr : '0;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule
